// File: rtl/demux_strobe_arbiter.sv
// demux_strobe_arbiter: round-robin sequencer sharing one 74x238 decoder across eight requesters
module demux_strobe_arbiter #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] req,
  output logic [2:0] a,
  output logic       g1,
  output logic       ng2a,
  output logic       ng2b,
  output logic [7:0] ack,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_cnt, w_cnt;
  logic [2:0] r_a, r_last, w_a, w_win, w_idx;
  logic [7:0] r_ack, w_ack;
  logic       r_g1, r_busy, w_done;
  always_comb begin
    w_win = r_last;
    w_idx = r_last;
    for (int i = 8; i >= 1; i--) begin
      w_idx = r_last + i[2:0];
      if (req[w_idx]) w_win = w_idx;
    end
  end
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt - 4'd1;
    w_a    = r_a;
    w_done = r_cnt == 4'd0;
    case (r_state)
      IDLE: begin
        w_cnt = r_cnt;
        if (req != 8'd0) begin
          w_next = SETUP;
          w_cnt  = 4'(SETUP_CYCLES - 1);
          w_a    = w_win;
        end
      end
      SETUP:  if (w_done) begin w_next = STROBE; w_cnt = 4'(STROBE_CYCLES - 1); end
      STROBE: if (w_done) begin w_next = HOLD;   w_cnt = 4'(HOLD_CYCLES - 1);   end
      default: if (w_done) begin w_next = IDLE;  w_cnt = 4'd0;                  end
    endcase
    w_ack = (w_next == HOLD && w_cnt == 4'd0) ? 8'd1 << w_a : 8'd0;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_a     <= 3'd0;
      r_last  <= 3'd7;
      r_ack   <= 8'd0;
      r_g1    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_a     <= w_a;
      r_last  <= (r_state == HOLD && w_done) ? r_a : r_last;
      r_ack   <= w_ack;
      r_g1    <= w_next == STROBE;
      r_busy  <= w_next != IDLE;
    end
  end
  assign a    = r_a;
  assign g1   = r_g1;
  assign ng2a = ~r_g1;
  assign ng2b = ~r_g1;
  assign ack  = r_ack;
  assign busy = r_busy;
endmodule

// File: tb/tb_demux_strobe_arbiter.sv
// tb_demux_strobe_arbiter: directed checks of grant sequencing, rotation, reset abort and decoder strobes
module tb_demux_strobe_arbiter;
  logic       clk = 1'b0;
  logic       nreset;
  logic [7:0] req;
  logic [2:0] a;
  logic       g1, ng2a, ng2b, busy;
  logic [7:0] ack;
  logic [7:0] y;
  int         n_chk = 0;
  int         n_fail = 0;
  demux_strobe_arbiter dut (
    .clk(clk), .nreset(nreset), .req(req), .a(a), .g1(g1),
    .ng2a(ng2a), .ng2b(ng2b), .ack(ack), .busy(busy)
  );
  always #5 clk = ~clk;
  assign y = (g1 && !ng2a && !ng2b) ? 8'd1 << a : 8'd0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic grant(input logic [2:0] idx, input int drop);
    int w;
    logic [7:0] oh;
    oh = 8'd1 << idx;
    w = 0;
    do begin tick(); w++; end while (!busy && w < 20);
    check("lat", w, 1);
    check("setup_a", a, idx);
    check("setup_y", y, 0);
    check("setup_en", {g1, ng2a, ng2b}, 3'b011);
    check("setup_ack", ack, 0);
    if (drop == 1) req[idx] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick();
      check("strobe_y", y, oh);
      check("strobe_en", {g1, ng2a, ng2b}, 3'b100);
      check("strobe_ack", ack, 0);
    end
    tick();
    check("hold_y", y, 0);
    check("hold_en", {g1, ng2a, ng2b}, 3'b011);
    check("hold_ack", ack, oh);
    check("hold_busy", busy, 1);
    check("hold_a", a, idx);
    if (drop == 2) req[idx] = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    check("idle_ack", ack, 0);
  endtask
  initial begin
    nreset = 1'b0;
    req = 8'h00;
    repeat (3) tick();
    check("rst_a", a, 0);
    check("rst_en", {g1, ng2a, ng2b}, 3'b011);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_y", y, 0);
    req = 8'hFF;
    repeat (2) tick();
    check("rst_req_busy", busy, 0);
    check("rst_req_y", y, 0);
    req = 8'h00;
    nreset = 1'b1;
    tick();
    req = 8'h08;
    grant(3, 2);
    req = 8'h04;
    grant(2, 2);
    req = 8'h24;
    grant(5, 2);
    grant(2, 2);
    req = 8'h40;
    tick();
    check("mid_setup_a", a, 6);
    tick();
    check("mid_strobe_y", y, 8'h40);
    nreset = 1'b0;
    #1;
    check("mid_rst_y", y, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_a", a, 0);
    repeat (3) begin
      tick();
      check("mid_rst_ack", ack, 0);
    end
    req = 8'h41;
    nreset = 1'b1;
    grant(0, 2);
    grant(6, 2);
    nreset = 1'b0;
    tick();
    req = 8'hFF;
    nreset = 1'b1;
    for (int i = 0; i < 9; i++) grant(3'(i % 8), 0);
    req = 8'h00;
    tick();
    check("flush_busy", busy, 0);
    req = 8'h10;
    grant(4, 1);
    check("drop_req", req, 0);
    repeat (3) begin
      tick();
      check("drop_idle", busy, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
